req_dispatch_queue: RTL
=======================

Name: req_dispatch_queue

Overview:
Parametrised successor to the two-channel AES/SHA request queue. It accepts full instructions from the deserializer and routes each one by opcode into one of NCH independent FIFOs (channel 0 = AES, channel 1 = SHA, more for future engines). Each channel presents entries to its FSM over a first-word-fall-through valid/ready handshake. The block exposes per-channel occupancy and reports instructions addressed to channels that do not exist.

Parameters:
ADDRW, 24, address field width
OPCODEW, 2, opcode width; must satisfy 2**OPCODEW >= NCH
QDEPTH, 16, entries per channel; power of 2, >= 2
NCH, 2, number of engine channels, >= 1
CHW, max(1,$clog2(NCH)), channel select width (derived; low CHW opcode bits)
INSTRW, 3*ADDRW+OPCODEW, instruction width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
valid_in  in  1  deserializer has an instruction
ready_out  out  1  combinational: target channel (from opcode) can accept
opcode  in  OPCODEW  operation; opcode[CHW-1:0] = channel id
key_addr  in  ADDRW  key address
text_addr  in  ADDRW  text address
dest_addr  in  ADDRW  destination address
instr_out  out  NCH*INSTRW  channel c at [c*INSTRW +: INSTRW], packed {opcode,key,text,dest}
valid_out  out  NCH  channel c head entry valid
ready_in  in  NCH  FSM c takes the head entry
count  out  NCH*($clog2(QDEPTH)+1)  per-channel occupancy, 0..QDEPTH
full  out  NCH  count==QDEPTH
err_bad_ch  out  1  one-cycle pulse: accepted instruction had channel id >= NCH

Behaviour:
- Reset (async, rst_n=0): all pointers and counts 0, valid_out=0, full=0, err_bad_ch=0. instr_out is don't-care but is driven to 0 by reset of the storage-read path.
- ch = opcode[CHW-1:0]. ready_out = (ch >= NCH) ? 1 : !full[ch]. This is combinational from opcode and registered state only, with no dependency on valid_in.
- Push: valid_in && ready_out && ch<NCH. The entry is written at wr_ptr[ch], and wr_ptr and count update on the same clk edge.
- Bad channel: valid_in && ch>=NCH. The instruction is consumed and discarded; err_bad_ch=1 for the next cycle only.
- Pop: valid_out[c] && ready_in[c]. rd_ptr[c] advances and count decrements on that edge. ready_in without valid_out has no effect.
- FWFT:
  - valid_out[c] = count[c]!=0, registered.
  - instr_out[c] = mem[c][rd_ptr[c]].
  - A push into an empty channel gives valid_out=1 in the following cycle (latency 1). There is no same-cycle bypass.
- Pointers are log2(QDEPTH) bits and wrap naturally from QDEPTH-1 to 0. The count tracks full/empty unambiguously.
- Simultaneous push and pop on the same channel, not full: count is unchanged and both pointers advance.
- Push when full: ready_out=0, so the push is not accepted even if the same channel pops in that cycle. Full is registered, and there is no pass-through.
- Pop when empty is impossible, because valid_out=0.
- Channels are fully independent. A pop on c and a push on d≠c in the same cycle are both honoured.
- Reset mid-operation discards all queued entries. Upstream must retransmit.

Decomposition:
- Package req_queue_pkg holds:
  - the INSTRW function;
  - field offsets (DEST_LSB=0, TEXT_LSB=ADDRW, KEY_LSB=2*ADDRW, OP_LSB=3*ADDRW);
  - channel id constants CH_AES=0, CH_SHA=1.
- Sub-module req_fifo (WIDTH, DEPTH): single-channel FWFT FIFO with push, pop, head data, count, full and valid. The top instantiates NCH copies in a generate loop and adds routing, ready_out and err_bad_ch logic.

Test Plan:
- Reset, then push one instruction {op=2'b00, key=24'h000001, text=24'h000002, dest=24'h000003} → the next cycle valid_out=2'b01 and instr_out[0]=that packed word. With ready_in[0]=1 held for one edge, valid_out[0]=0 and count[0]=0.
- Push 16 SHA ops (op=2'b01, dest=0..15) with ready_in=0 → full[1]=1 and ready_out=0 for op=01 while ready_out=1 for op=00. A 17th push is ignored. The drain yields dest 0..15 in order.
- Fill channel 0, then each cycle pop and attempt a push → pushes are rejected only while full. After one pop the next push is accepted, and wrap-around order is preserved across 40 entries.
- NCH=3, OPCODEW=2: push op=2'b11 → ready_out=1, err_bad_ch pulses for one cycle, and all counts stay 0.
- Interleave AES/SHA pushes with random ready_in on both channels for 1000 cycles → per-channel output order matches the scoreboard and count always equals pushes minus pops.
- Assert rst_n low mid-stream with 5 entries queued → valid_out=0 and counts=0 immediately, with nothing left to drain after release.

Source files
------------

// File: rtl/req_queue_pkg.sv
// rtl/req_queue_pkg.sv - shared constants and layout helpers for the request dispatch queue
package req_queue_pkg;

   localparam int CH_AES   = 0;
   localparam int CH_SHA   = 1;
   localparam int DEST_LSB = 0;

   function automatic int instr_w(input int addrw, input int opcodew);
      return 3 * addrw + opcodew;
   endfunction

   function automatic int text_lsb(input int addrw);
      return addrw;
   endfunction

   function automatic int key_lsb(input int addrw);
      return 2 * addrw;
   endfunction

   function automatic int op_lsb(input int addrw);
      return 3 * addrw;
   endfunction

endpackage

// File: rtl/req_dispatch_queue_fifo.sv
// rtl/req_dispatch_queue_fifo.sv - single-channel first-word-fall-through FIFO
module req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             valid,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CW-1:0]    count_nxt;

   // full and valid are registered copies of the next count, so neither is combinational from push/pop
   assign do_push   = push && !full;
   assign do_pop    = pop && valid;
   assign count_nxt = count + CW'(do_push) - CW'(do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         valid <= (count_nxt != '0);
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

   assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/req_dispatch_queue.sv
// rtl/req_dispatch_queue.sv - routes instructions by opcode into per-engine FWFT queues
module req_dispatch_queue
   import req_queue_pkg::*;
#(
   parameter int ADDRW   = 24,
   parameter int OPCODEW = 2,
   parameter int QDEPTH  = 16,
   parameter int NCH     = 2,
   localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int INSTRW = instr_w(ADDRW, OPCODEW),
   localparam int CNTW   = $clog2(QDEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [OPCODEW-1:0]    opcode,
   input  logic [ADDRW-1:0]      key_addr,
   input  logic [ADDRW-1:0]      text_addr,
   input  logic [ADDRW-1:0]      dest_addr,
   output logic [NCH*INSTRW-1:0] instr_out,
   output logic [NCH-1:0]        valid_out,
   input  logic [NCH-1:0]        ready_in,
   output logic [NCH*CNTW-1:0]   count,
   output logic [NCH-1:0]        full,
   output logic                  err_bad_ch
);

   localparam int TEXT_LSB = text_lsb(ADDRW);
   localparam int KEY_LSB  = key_lsb(ADDRW);
   localparam int OP_LSB   = op_lsb(ADDRW);
   localparam logic [CHW:0] NCH_V = (CHW + 1)'(NCH);

   logic [CHW-1:0]    ch;
   logic              bad_ch;
   logic [INSTRW-1:0] wdata;
   logic [NCH-1:0]    push;

   assign ch     = opcode[CHW-1:0];
   assign bad_ch = ({1'b0, ch} >= NCH_V);

   assign wdata[DEST_LSB +: ADDRW]  = dest_addr;
   assign wdata[TEXT_LSB +: ADDRW]  = text_addr;
   assign wdata[KEY_LSB  +: ADDRW]  = key_addr;
   assign wdata[OP_LSB   +: OPCODEW] = opcode;

   // Nonexistent channels always look ready so the deserializer can flush them
   always_comb begin
      ready_out = 1'b1;
      push      = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ch == CHW'(c)) begin
            ready_out = !full[c];
            push[c]   = valid_in && !full[c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_bad_ch <= 1'b0;
      else        err_bad_ch <= valid_in && bad_ch;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      req_fifo #(
         .WIDTH (INSTRW),
         .DEPTH (QDEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[c]),
         .wdata (wdata),
         .pop   (ready_in[c]),
         .rdata (instr_out[c*INSTRW +: INSTRW]),
         .valid (valid_out[c]),
         .full  (full[c]),
         .count (count[c*CNTW +: CNTW])
      );
   end

endmodule
